// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared debouncer FSM state type and tick divisor helper
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    HIGH   = 2'd2,
    DISARM = 2'd3
  } db_state_t;

  // Clock cycles per sample tick; never less than one so the divider always advances
  function automatic int calc_div(input logic [27:0] f_clk, input logic [27:0] f_tick);
    int unsigned q;
    if (f_tick == '0) return 1;
    q = 32'(f_clk / f_tick);
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle tick every DIV clocks
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic sys_clk_in,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise, sample and debounce one push button (BTN_RELEASE_PULSE_EN adds a release strobe)
module button_debouncer
  import debounce_pkg::*;
#(
  parameter logic [27:0] clk_freq      = 28'd1000_0000,
  parameter logic [27:0] debounce_freq = 28'd500_0000,
  parameter int          STABLE_TICKS  = 4
) (
  input  logic sys_clk_in,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic press_flag
`ifdef BTN_RELEASE_PULSE_EN
  ,
  output logic btn_release_pulse
`endif
);

  localparam int DIV = calc_div(clk_freq, debounce_freq);
  localparam logic [3:0] ST = 4'(STABLE_TICKS);

  logic      s1;
  logic      btn_sync;
  logic      tick;
  db_state_t state;
  logic [3:0] stab_cnt;
  logic      press_accept;
  logic      release_accept;

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      s1       <= btn_raw;
      btn_sync <= s1;
    end
  end

  tick_divider #(.DIV(DIV)) u_tick (
    .sys_clk_in (sys_clk_in),
    .reset      (reset),
    .tick       (tick)
  );

  // With a single required tick the first agreeing sample is accepted directly
  always_comb begin
    press_accept   = 1'b0;
    release_accept = 1'b0;
    if (tick) begin
      case (state)
        IDLE:    press_accept   = btn_sync && (ST == 4'd1);
        ARM:     press_accept   = btn_sync && (stab_cnt + 4'd1 == ST);
        HIGH:    release_accept = !btn_sync && (ST == 4'd1);
        DISARM:  release_accept = !btn_sync && (stab_cnt + 4'd1 == ST);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      stab_cnt   <= 4'd0;
      btn_level  <= 1'b0;
      btn_pulse  <= 1'b0;
      press_flag <= 1'b0;
    end else begin
      btn_pulse <= press_accept;
      if (press_accept) begin
        state      <= HIGH;
        stab_cnt   <= 4'd0;
        btn_level  <= 1'b1;
        press_flag <= ~press_flag;
      end else if (release_accept) begin
        state     <= IDLE;
        stab_cnt  <= 4'd0;
        btn_level <= 1'b0;
      end else if (tick) begin
        case (state)
          IDLE: if (btn_sync) begin
            state    <= ARM;
            stab_cnt <= 4'd1;
          end
          ARM: if (btn_sync) begin
            stab_cnt <= stab_cnt + 4'd1;
          end else begin
            state    <= IDLE;
            stab_cnt <= 4'd0;
          end
          HIGH: if (!btn_sync) begin
            state    <= DISARM;
            stab_cnt <= 4'd1;
          end
          DISARM: if (!btn_sync) begin
            stab_cnt <= stab_cnt + 4'd1;
          end else begin
            state    <= HIGH;
            stab_cnt <= 4'd0;
          end
          default: begin
            state    <= IDLE;
            stab_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

`ifdef BTN_RELEASE_PULSE_EN
  always_ff @(posedge sys_clk_in or negedge reset) begin
    if (!reset) begin
      btn_release_pulse <= 1'b0;
    end else begin
      btn_release_pulse <= release_accept;
    end
  end
`endif

endmodule
